// File: rtl/multiplier_5b_if.sv
// Operand/result bus of the 5-bit shift-add multiplier.
// The DUT side uses modport slave; the driver side uses modport master.
interface multiplier_5b_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] dataIN;
    logic             selOut;
    logic [WIDTH-1:0] dataOUT;
    logic             ready;
    logic             done;
    logic             ProdZero;

    modport master (
        output start, dataIN, selOut,
        input  dataOUT, ready, done, ProdZero
    );

    modport slave (
        input  start, dataIN, selOut,
        output dataOUT, ready, done, ProdZero
    );
endinterface

// File: rtl/multiplier_5b.sv
// Sequential unsigned shift-add multiplier producing the product {A,Q}.
// Each operation takes one cycle per bit, with no early exit.
module multiplier_5b #(
    parameter int WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    multiplier_5b_if.slave    bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOADM = 2'd1;
    localparam logic [1:0] CALC  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [2:0] LAST  = 3'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // Carry out is sum[WIDTH] and is shifted straight back into A.
    assign sum = {1'b0, a_q} + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                q_d     = bus.dataIN;
                a_d     = '0;
                cnt_d   = '0;
                state_d = LOADM;
            end
            LOADM: begin
                m_d     = bus.dataIN;
                state_d = CALC;
            end
            CALC: begin
                a_d   = sum[WIDTH:1];
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.dataOUT  = bus.selOut ? q_q : a_q;
    assign bus.ready    = (state_q == IDLE);
    assign bus.done     = (state_q == DONE);
    assign bus.ProdZero = (a_q == '0) && (q_q == '0);
endmodule

// File: tb/tb_multiplier_5b.sv
// Directed bench for multiplier_5b: reset values, products, latency, start/dataIN
// immunity while busy, mid-operation reset and back-to-back starts.
module tb_multiplier_5b;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    multiplier_5b_if #(.WIDTH(5)) bus ();

    multiplier_5b #(.WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done; n arrives holding the edges already taken.
    task automatic wait_done(inout int n, input bit glitch);
        while (!bus.done && n < 20) begin
            if (glitch && n == 3) begin
                bus.start  = 1'b1;
                bus.dataIN = 5'd31;
            end else if (glitch) begin
                bus.start  = 1'b0;
                bus.dataIN = 5'd13;
            end
            step;
            n++;
        end
    endtask

    task automatic chk_prod(input string tag, input int hi, input int lo, input bit pz);
        bus.selOut = 1'b0; #1;
        chk({tag, ".hi"}, 32'(bus.dataOUT), hi);
        bus.selOut = 1'b1; #1;
        chk({tag, ".lo"}, 32'(bus.dataOUT), lo);
        chk({tag, ".pz"}, 32'(bus.ProdZero), 32'(pz));
    endtask

    task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input int hi, input int lo, input bit pz, input bit glitch);
        int n;
        bus.start = 1'b1; bus.dataIN = a;
        step;
        chk({tag, ".busy"}, 32'(bus.ready), 0);
        bus.start = 1'b0; bus.dataIN = b;
        step;
        bus.dataIN = 5'd13;
        n = 1;
        wait_done(n, glitch);
        bus.start = 1'b0;
        chk({tag, ".lat"}, 32'(n), 6);
        chk_prod(tag, hi, lo, pz);
        step;
        chk({tag, ".pulse"}, 32'(bus.done), 0);
        chk({tag, ".idle"}, 32'(bus.ready), 1);
        chk_prod({tag, ".hold"}, hi, lo, pz);
    endtask

    initial begin
        int  n;
        bit  saw_done;
        bus.start = 1'b0; bus.dataIN = '0; bus.selOut = 1'b0;
        #2;
        chk("rst.ready", 32'(bus.ready), 1);
        chk("rst.done", 32'(bus.done), 0);
        chk_prod("rst", 0, 0, 1'b1);
        step;
        rst = 1'b0;
        step;

        run_op("m31x31", 5'd31, 5'd31, 30, 1, 1'b0, 1'b0);
        run_op("m5x6",   5'd5,  5'd6,  0, 30, 1'b0, 1'b0);
        run_op("m0x17",  5'd0,  5'd17, 0, 0,  1'b1, 1'b0);
        run_op("m3x7g",  5'd3,  5'd7,  0, 21, 1'b0, 1'b1);

        // Reset during the third CALC cycle aborts with no done pulse.
        bus.start = 1'b1; bus.dataIN = 5'd3;
        step;
        bus.start = 1'b0; bus.dataIN = 5'd7;
        step; step; step;
        #2;
        rst = 1'b1;
        #1;
        chk("abort.ready", 32'(bus.ready), 1);
        chk("abort.done", 32'(bus.done), 0);
        chk_prod("abort", 0, 0, 1'b1);
        saw_done = 1'b0;
        step;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort.nodone", 32'(saw_done), 0);
        run_op("m2x9", 5'd2, 5'd9, 0, 18, 1'b0, 1'b0);

        // start held high: 4x4 then 2x3 back to back.
        bus.start = 1'b1; bus.dataIN = 5'd4;
        step;
        bus.dataIN = 5'd4;
        step;
        n = 1;
        wait_done(n, 1'b0);
        chk("b2b1.lat", 32'(n), 6);
        chk("b2b1.busy", 32'(bus.ready), 0);
        chk_prod("b2b1", 0, 16, 1'b0);
        bus.dataIN = 5'd2;
        step;
        chk("b2b.idle", 32'(bus.ready), 1);
        chk("b2b.pulse", 32'(bus.done), 0);
        step;
        chk("b2b2.busy", 32'(bus.ready), 0);
        bus.dataIN = 5'd3;
        step;
        n = 1;
        wait_done(n, 1'b0);
        chk("b2b2.lat", 32'(n), 6);
        chk_prod("b2b2", 0, 6, 1'b0);
        bus.start = 1'b0;
        step;
        chk("b2b2.idle", 32'(bus.ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
